// File: rtl/ffra_sched_pkg.sv
// Shared widths, requester id and pipeline record types for the two-requester
// multiply-add scheduler.
package ffra_sched_pkg;

  localparam int LAT_MAX = 4;
  localparam int A_W     = 8;
  localparam int B_W     = 8;
  localparam int C_W     = 16;

  typedef logic id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] ci;
  } opnd_t;

endpackage

// File: rtl/ffra_sched_ffra.sv
// Registered multiply-add datapath: o = (a*b + ci) mod 2^16, valid LAT rising
// edges after a/b/ci are presented.
module ffra
  import ffra_sched_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] ci,
  output logic [C_W-1:0] o
);

  logic [C_W-1:0] sum_d;
  logic [C_W-1:0] pipe_q [LAT];

  // Zero-extend so the product is a full 16-bit unsigned value; the add's carry drops.
  assign sum_d = ({{(C_W-A_W){1'b0}}, a} * {{(C_W-B_W){1'b0}}, b}) + ci;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= sum_d;
      // NOTE: non-blocking assignments make every stage read last cycle's value, so loop order is irrelevant.
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign o = pipe_q[LAT-1];

endmodule

// File: rtl/ffra_sched.sv
// Two requesters share one multiply-add datapath; round-robin issue, one
// outstanding operation per requester, per-requester result slots.
module ffra_sched
  import ffra_sched_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic [C_W-1:0] req0_ci,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  input  logic [C_W-1:0] req1_ci,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [C_W-1:0] rsp0_o,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [C_W-1:0] rsp1_o,
  output logic           busy,
  output logic [15:0]    done_cnt
);

  logic [1:0]     elig;
  logic [1:0]     gnt;
  logic [1:0]     rsp_hs;
  logic [1:0]     pend_q;
  logic [1:0]     slot_vld_q;
  logic           last_q;
  tag_t           iss_q;
  opnd_t          opnd_q;
  tag_t           tag_q [LAT];
  tag_t           tag_out;
  logic [C_W-1:0] slot_q [2];
  logic [C_W-1:0] dp_o;
  logic [15:0]    cnt_q;

  assign elig = {req1_valid & ~pend_q[1], req0_valid & ~pend_q[0]};

  always_comb begin
    gnt = 2'b00;
    // NOTE: gated by rst because pend_q alone would still let a valid requester see ready during reset.
    if (!rst) begin
      if (elig == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else               gnt = elig;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp_hs     = slot_vld_q & {rsp1_ready, rsp0_ready};

  ffra #(.LAT(LAT)) u_ffra (
    .clk (clk),
    .rst (rst),
    .a   (opnd_q.a),
    .b   (opnd_q.b),
    .ci  (opnd_q.ci),
    .o   (dp_o)
  );

  // The tag leaving the last stage lines up with the datapath result.
  assign tag_out = tag_q[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      last_q     <= 1'b1;
      iss_q      <= '0;
      opnd_q     <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      slot_vld_q <= '0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      cnt_q      <= '0;
    end else begin
      pend_q <= (pend_q & ~rsp_hs) | gnt;
      if (|gnt) begin
        last_q <= gnt[1];
        if (gnt[1]) opnd_q <= '{a: req1_a, b: req1_b, ci: req1_ci};
        else        opnd_q <= '{a: req0_a, b: req0_b, ci: req0_ci};
      end
      iss_q    <= '{valid: |gnt, id: gnt[1]};
      tag_q[0] <= iss_q;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      slot_vld_q <= slot_vld_q & ~rsp_hs;
      if (tag_out.valid) begin
        slot_vld_q[tag_out.id] <= 1'b1;
        slot_q[tag_out.id]     <= dp_o;
      end
      cnt_q <= cnt_q + 16'(rsp_hs[0]) + 16'(rsp_hs[1]);
    end
  end

  assign rsp0_valid = slot_vld_q[0];
  assign rsp1_valid = slot_vld_q[1];
  assign rsp0_o     = slot_q[0];
  assign rsp1_o     = slot_q[1];
  assign busy       = |pend_q;
  assign done_cnt   = cnt_q;

endmodule

// File: doc/ffra_sched.md
FFRA_SCHED -- requirements
Module: ffra_sched

Interface
REQ-001 Parameter: LAT, default 1, datapath latency in clock edges (legal 1..4).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req0_valid / req1_valid  in  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  out  1  grant; an operation transfers when valid && ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  8  multiplicand and multiplier.
REQ-007 req0_ci / req1_ci  in  16  addend.
REQ-008 rsp0_valid / rsp1_valid  out  1  result available for requester i.
REQ-009 rsp0_ready / rsp1_ready  in  1  requester i accepts its result.
REQ-010 rsp0_o / rsp1_o  out  16  result, (a*b + ci) mod 2^16.
REQ-011 busy  out  1  any operation in flight or any result slot full.
REQ-012 done_cnt  out  16  count of completed result handshakes.

Function
REQ-013 The block SHALL share one datapath instance between the two requesters, issuing at most one operation per cycle.
REQ-014 Per requester, pend_i SHALL be set on an issue handshake and cleared on the rsp_i handshake; at most one operation per requester is outstanding.
REQ-015 Requester i SHALL be eligible when req_i_valid && !pend_i, using registered pend_i only (no same-cycle bypass from the rsp handshake).
REQ-016 When exactly one requester is eligible, it SHALL be granted; when both are eligible, the one not granted most recently SHALL be granted.
REQ-017 req_i_ready SHALL be combinational from eligibility and the arbitration pointer, with no dependence on req_i_valid of the other requester beyond arbitration.
REQ-018 Datapath operands SHALL be muxed from the granted requester; a valid+id tag SHALL travel in a LAT-deep shift register alongside the datapath.
REQ-019 When the tag emerges with id i, the datapath output SHALL load slot i, and rsp_i_valid SHALL rise LAT+1 edges after the issue edge.
REQ-020 rsp_i_o SHALL hold stable while rsp_i_valid && !rsp_i_ready; the slot SHALL clear on handshake.
REQ-021 Arithmetic: the product is 16-bit unsigned, the sum is truncated to 16 bits, and carry-out is discarded.
REQ-022 done_cnt SHALL add 1 or 2 per cycle (two simultaneous rsp handshakes add 2) and wrap modulo 2^16.
REQ-023 busy SHALL equal OR(pend_0, pend_1).
REQ-024 Invalid operand values while valid is low SHALL not affect state.

Reset
REQ-025 While rst is high, the block SHALL hold these values: req_i_ready=0, rsp_i_valid=0, rsp_i_o=0, pend_i=0, all tags invalid, busy=0, done_cnt=0.
REQ-026 rst SHALL set the arbitration pointer to favour requester 0.
REQ-027 rst asserted mid-operation SHALL discard in-flight results; no rsp_valid SHALL appear for pre-reset issues after release.

Structure
REQ-028 The shared package SHALL hold LAT_MAX=4, the operand widths (8/8/16), and the requester id type (1 bit).
REQ-029 The one natural sub-module SHALL be ffra (clk, rst, a, b, ci, o), the registered multiply-add datapath; the tag pipeline and arbiter stay in ffra_sched.

Verification
REQ-030 With LAT=1, req0 issues a=3, b=4, ci=5 at edge E0 -> rsp0_valid=1 after E2, rsp0_o=17, done_cnt=1 after the handshake.
REQ-031 Wrap case: a=255, b=255, ci=0xFFFF -> rsp_o=0xFE00.
REQ-032 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; each requester issues again only after its own rsp handshake.
REQ-033 rsp0_ready=0 for 10 cycles -> rsp0_o stays constant, req0_ready stays 0, and req1 continues to be served.
REQ-034 rst pulsed one cycle after an issue with LAT=3 -> no rsp_valid ever appears for that issue, and busy=0, done_cnt=0.
REQ-035 Simultaneous rsp0 and rsp1 handshakes in one cycle -> done_cnt increments by 2; at 0xFFFF the increment wraps to 0x0001.
